stream_match_sched: RTL and testbench

- Shared serial pattern-match engine plus a scheduler for it.
- Up to NUM_REQ requesters each ask to stream a frame of bits through the engine. Requests are granted round-robin.
- The granted frame is checked against a runtime-programmed pattern of 1..PAT_W bits. Overlapping matches are counted.
- One result per frame is returned on a valid/ready interface. This replaces one hard-coded detector instance per stream.

---
 rtl/stream_match_sched.sv | 201 ++++++++++++++++++++
 tb/tb_stream_match_sched.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_match_sched.sv
// stream_match_sched: a single serial pattern-match engine shared by
// NUM_REQ requesters. Requests are granted round-robin. The granted
// frame's bits are compared against a runtime-programmed pattern of
// 1..PAT_W bits, and overlapping matches are counted with saturation.
// One result per frame is returned on a valid/ready interface.
//
// Optional build macro STREAM_MATCH_NONOVERLAP_EN: when defined, the
// history and fill counter are cleared after each match, so two matches
// never share bits. When undefined, overlapping matches are counted.
//
// Handshakes: a bit transfers on a rising edge where in_valid and
// in_ready are both high. A result transfers on a rising edge where
// res_valid and res_ready are both high. While res_valid is high,
// res_id and res_count hold steady until that edge.
//
// PAT_W must be at least 2 because the history shift keeps PAT_W-1 old bits.
module stream_match_sched #(
    parameter int NUM_REQ = 4,
    parameter int PAT_W   = 8,
    parameter int LEN_W   = 8,
    parameter int CNT_W   = 8,
    localparam int ID_W   = $clog2(NUM_REQ),
    localparam int PLEN_W = $clog2(PAT_W + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_we,
    input  logic [PAT_W-1:0]         cfg_pattern,
    input  logic [PLEN_W-1:0]        cfg_plen,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*LEN_W-1:0] req_len,
    output logic [NUM_REQ-1:0]       gnt,
    input  logic                     in_valid,
    input  logic                     in_bit,
    output logic                     in_ready,
    output logic                     found,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [ID_W-1:0]          res_id,
    output logic [CNT_W-1:0]         res_count,
    output logic [1:0]               dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_REPORT = 2'd2
    } state_t;

    state_t              r_state;
    logic [ID_W-1:0]     r_ptr;
    logic [ID_W-1:0]     r_id;
    logic [PAT_W-1:0]    r_pattern;
    logic [PLEN_W-1:0]   r_plen;
    logic [PAT_W-1:0]    r_hist;
    logic [PLEN_W-1:0]   r_fill;
    logic [LEN_W-1:0]    r_rem;
    logic [CNT_W-1:0]    r_count;
    logic [NUM_REQ-1:0]  r_gnt;
    logic                r_in_ready;
    logic                r_found;
    logic                r_res_valid;

    logic                w_pick_any;
    logic [ID_W-1:0]     w_pick_idx;
    logic [LEN_W-1:0]    w_pick_len;
    logic [PLEN_W-1:0]   w_cfg_plen;
    logic [PAT_W-1:0]    w_hist_new;
    logic [PLEN_W-1:0]   w_fill_new;
    logic [PAT_W-1:0]    w_mask;
    logic                w_match;
    logic                w_accept;
    logic [CNT_W-1:0]    w_count_inc;

    // Round-robin pick: first set req bit at or above the pointer, wrapping.
    // Scanning from the far end lets the nearest candidate win last.
    always_comb begin
        w_pick_any = 1'b0;
        w_pick_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[(int'(r_ptr) + k) % NUM_REQ]) begin
                w_pick_any = 1'b1;
                w_pick_idx = ID_W'((int'(r_ptr) + k) % NUM_REQ);
            end
        end
    end

    assign w_pick_len = req_len[int'(w_pick_idx)*LEN_W +: LEN_W];

    // Lengths beyond the history depth behave as a full-width pattern.
    assign w_cfg_plen = (cfg_plen > PLEN_W'(PAT_W)) ? PLEN_W'(PAT_W) : cfg_plen;

    // Candidate history and fill level as if the current bit were accepted.
    assign w_hist_new = {r_hist[PAT_W-2:0], in_bit};
    assign w_fill_new = (r_fill == PLEN_W'(PAT_W)) ? r_fill : r_fill + PLEN_W'(1);

    // Compare mask selects the low plen bits of history and pattern.
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < PAT_W; i++) begin
            w_mask[i] = (i < int'(r_plen));
        end
    end

    assign w_match = (r_plen != '0) &&
                     (w_fill_new >= r_plen) &&
                     (((w_hist_new ^ r_pattern) & w_mask) == '0);

    assign w_accept    = (r_state == ST_STREAM) && in_valid && r_in_ready;
    assign w_count_inc = (r_count == '1) ? r_count : r_count + CNT_W'(1);

    // Scheduler / engine FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_ptr       <= '0;
            r_id        <= '0;
            r_pattern   <= '0;
            r_plen      <= '0;
            r_hist      <= '0;
            r_fill      <= '0;
            r_rem       <= '0;
            r_count     <= '0;
            r_gnt       <= '0;
            r_in_ready  <= 1'b0;
            r_found     <= 1'b0;
            r_res_valid <= 1'b0;
        end else begin
            r_found <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (cfg_we) begin
                        r_pattern <= cfg_pattern;
                        r_plen    <= w_cfg_plen;
                    end
                    if (w_pick_any) begin
                        r_id    <= w_pick_idx;
                        r_rem   <= w_pick_len;
                        r_hist  <= '0;
                        r_fill  <= '0;
                        r_count <= '0;
                        r_gnt   <= NUM_REQ'(1) << w_pick_idx;
                        if (w_pick_len == '0) begin
                            r_state     <= ST_REPORT;
                            r_res_valid <= 1'b1;
                        end else begin
                            r_state    <= ST_STREAM;
                            r_in_ready <= 1'b1;
                        end
                    end
                end

                ST_STREAM: begin
                    if (w_accept) begin
                        r_rem  <= r_rem - LEN_W'(1);
                        r_hist <= w_hist_new;
                        r_fill <= w_fill_new;
                        if (w_match) begin
                            r_found <= 1'b1;
                            r_count <= w_count_inc;
`ifdef STREAM_MATCH_NONOVERLAP_EN
                            r_hist  <= '0;
                            r_fill  <= '0;
`endif
                        end
                        if (r_rem == LEN_W'(1)) begin
                            r_state     <= ST_REPORT;
                            r_in_ready  <= 1'b0;
                            r_res_valid <= 1'b1;
                        end
                    end
                end

                ST_REPORT: begin
                    if (res_ready) begin
                        r_state     <= ST_IDLE;
                        r_gnt       <= '0;
                        r_res_valid <= 1'b0;
                        r_ptr       <= (r_id == ID_W'(NUM_REQ - 1)) ? '0 : r_id + ID_W'(1);
                    end
                end

                default: begin
                    r_state     <= ST_IDLE;
                    r_gnt       <= '0;
                    r_in_ready  <= 1'b0;
                    r_res_valid <= 1'b0;
                end
            endcase
        end
    end

    assign gnt       = r_gnt;
    assign in_ready  = r_in_ready;
    assign found     = r_found;
    assign res_valid = r_res_valid;
    assign res_id    = r_id;
    assign res_count = r_count;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_stream_match_sched.sv
// Directed and randomized bench for stream_match_sched, checked against a
// frame-level reference model (bit queue per frame, round-robin pointer).
module tb_stream_match_sched;

  localparam int NUM_REQ = 4;
  localparam int PAT_W   = 8;
  localparam int LEN_W   = 8;
  localparam int CNT_W   = 4;
  localparam int ID_W    = 2;
  localparam int PLEN_W  = 4;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     cfg_we;
  logic [PAT_W-1:0]         cfg_pattern;
  logic [PLEN_W-1:0]        cfg_plen;
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*LEN_W-1:0] req_len;
  logic [NUM_REQ-1:0]       gnt;
  logic                     in_valid;
  logic                     in_bit;
  logic                     in_ready;
  logic                     found;
  logic                     res_valid;
  logic                     res_ready;
  logic [ID_W-1:0]          res_id;
  logic [CNT_W-1:0]         res_count;
  logic [1:0]               dbg_state;

  stream_match_sched #(
    .NUM_REQ(NUM_REQ), .PAT_W(PAT_W), .LEN_W(LEN_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
    .cfg_plen(cfg_plen), .req(req), .req_len(req_len), .gnt(gnt),
    .in_valid(in_valid), .in_bit(in_bit), .in_ready(in_ready), .found(found),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
    .res_count(res_count), .dbg_state(dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  int n_pass  = 0;
  int n_total = 0;

  logic [ID_W+CNT_W-1:0] exp_q[$];
  bit                    stim_q[$];
  bit                    hist_q[$];
  logic [PAT_W-1:0]      m_pat;
  int                    m_plen;
  int                    m_ptr;
  int                    m_cnt;
  int                    last_id;
  int                    last_count;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // reference: first requester at or after the pointer, wrapping
  function automatic int rr_pick(input logic [NUM_REQ-1:0] r, input int ptr);
    for (int k = 0; k < NUM_REQ; k++) begin
      if (r[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
    end
    return -1;
  endfunction

  // reference: append a bit to the frame and test the tail against the pattern
  function automatic bit model_bit(input bit b);
    int sz;
    hist_q.push_back(b);
    if (m_plen == 0) return 1'b0;
    sz = hist_q.size();
    if (sz < m_plen) return 1'b0;
    for (int k = 0; k < m_plen; k++) begin
      if (hist_q[sz - m_plen + k] != m_pat[m_plen - 1 - k]) return 1'b0;
    end
    m_cnt = (m_cnt < (1 << CNT_W) - 1) ? m_cnt + 1 : m_cnt;
`ifdef STREAM_MATCH_NONOVERLAP_EN
    hist_q.delete();
`endif
    return 1'b1;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    in_valid = 1'b0;
    cfg_we = 1'b0;
    res_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    m_ptr = 0;
    m_pat = '0;
    m_plen = 0;
    stim_q.delete();
  endtask

  task automatic cfg_set(input logic [PAT_W-1:0] p, input int pl);
    cfg_we = 1'b1;
    cfg_pattern = p;
    cfg_plen = PLEN_W'(pl);
    tick();
    cfg_we = 1'b0;
    m_pat = p;
    m_plen = (pl > PAT_W) ? PAT_W : pl;
  endtask

  task automatic set_len(input int id, input int len);
    req_len[id*LEN_W +: LEN_W] = LEN_W'(len);
  endtask

  // driver: wait for grant, stream the frame, then collect and check the result
  task automatic run_frame(input bit drop_req, input int bp, input bit cfg_mid, input bit gaps);
    int id, len, waited;
    bit m;
    logic [NUM_REQ-1:0] saved_req;
    logic [ID_W+CNT_W-1:0] e;
    id = rr_pick(req, m_ptr);
    if (id < 0) begin
      chk("no_request", 32'(req), 32'hFFFF_FFFF);
      return;
    end
    len = int'(req_len[id*LEN_W +: LEN_W]);
    while (stim_q.size() < len) stim_q.push_back(1'($urandom_range(0, 1)));
    waited = 0;
    while (gnt == '0 && waited < 20) begin
      tick();
      waited++;
    end
    chk("grant", 32'(gnt), 32'(1 << id));
    if (gnt == '0) begin
      stim_q.delete();
      return;
    end
    if (drop_req) req[id] = 1'b0;
    hist_q.delete();
    m_cnt = 0;
    chk("in_ready_at_grant", 32'(in_ready), (len == 0) ? 32'd0 : 32'd1);
    for (int j = 0; j < len; j++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        tick();
        chk("found_in_gap", 32'(found), 32'd0);
      end
      if (cfg_mid && j == 1) begin
        cfg_we = 1'b1;
        cfg_pattern = ~m_pat;
        cfg_plen = PLEN_W'(1);
      end
      in_valid = 1'b1;
      in_bit = stim_q[j];
      tick();
      cfg_we = 1'b0;
      in_valid = 1'b0;
      m = model_bit(stim_q[j]);
      chk("found", 32'(found), 32'(m));
    end
    stim_q.delete();
    exp_q.push_back((ID_W+CNT_W)'((id << CNT_W) | m_cnt));
    chk("res_valid", 32'(res_valid), 32'd1);
    chk("in_ready_report", 32'(in_ready), 32'd0);
    saved_req = req;
    for (int b = 0; b < bp; b++) begin
      req = '1;
      in_valid = 1'($urandom_range(0, 1));
      in_bit = 1'b1;
      tick();
      chk("bp_res_valid", 32'(res_valid), 32'd1);
      chk("bp_res_id", 32'(res_id), 32'(exp_q[0][ID_W+CNT_W-1:CNT_W]));
      chk("bp_res_count", 32'(res_count), 32'(exp_q[0][CNT_W-1:0]));
      chk("bp_gnt", 32'(gnt), 32'(1 << id));
      chk("bp_found", 32'(found), 32'd0);
    end
    req = saved_req;
    in_valid = 1'b0;
    e = exp_q.pop_front();
    chk("res_id", 32'(res_id), 32'(e[ID_W+CNT_W-1:CNT_W]));
    chk("res_count", 32'(res_count), 32'(e[CNT_W-1:0]));
    last_id = int'(res_id);
    last_count = int'(res_count);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("post_hs_gnt", 32'(gnt), 32'd0);
    chk("post_hs_res_valid", 32'(res_valid), 32'd0);
    m_ptr = (id + 1) % NUM_REQ;
  endtask

  initial begin
    rst = 1'b1;
    cfg_we = 1'b0;
    cfg_pattern = '0;
    cfg_plen = '0;
    req = '0;
    req_len = '0;
    in_valid = 1'b0;
    in_bit = 1'b0;
    res_ready = 1'b0;
    do_reset();

    // reset state
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_found", 32'(found), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_id", 32'(res_id), 32'd0);
    chk("rst_res_count", 32'(res_count), 32'd0);

    // basic match, config write and grant on the same edge
    set_len(0, 10);
    stim_q = '{0, 0, 1, 1, 0, 0, 0, 1, 1, 0};
    req = 4'b0001;
    cfg_set(8'b0000_0110, 5);
    run_frame(1'b1, 0, 1'b0, 1'b0);
    chk("basic_count", 32'(last_count), 32'd2);
    chk("basic_id", 32'(last_id), 32'd0);

    // overlap versus non-overlap
    cfg_set(8'b0000_0101, 3);
    set_len(0, 5);
    stim_q = '{1, 0, 1, 0, 1};
    req = 4'b0001;
    run_frame(1'b1, 0, 1'b0, 1'b1);
`ifdef STREAM_MATCH_NONOVERLAP_EN
    chk("overlap_count", 32'(last_count), 32'd1);
`else
    chk("overlap_count", 32'(last_count), 32'd2);
`endif

    // round-robin with all requesters held
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) set_len(i, 1);
    req = 4'b1111;
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      run_frame(1'b0, 0, 1'b0, 1'b0);
      chk("rr_order", 32'(last_id), 32'(i % NUM_REQ));
    end
    req = 4'b0100;
    run_frame(1'b1, 0, 1'b0, 1'b0);
    chk("rr_single", 32'(last_id), 32'd2);
    req = 4'b0101;
    run_frame(1'b0, 0, 1'b0, 1'b0);
    chk("rr_wrap", 32'(last_id), 32'd0);
    req = '0;

    // zero-length frame
    set_len(1, 0);
    req = 4'b0010;
    run_frame(1'b1, 0, 1'b0, 1'b0);
    chk("zero_len_count", 32'(last_count), 32'd0);

    // backpressure and config lock during the stream
    cfg_set(8'b0000_0011, 2);
    set_len(3, 8);
    stim_q = '{0, 1, 1, 1, 0, 1, 1, 0};
    req = 4'b1000;
    run_frame(1'b1, 5, 1'b1, 1'b0);
    chk("cfg_lock_count", 32'(last_count), 32'd3);

    // saturation of the match counter
    cfg_set(8'b0000_0001, 1);
    set_len(1, 20);
    for (int i = 0; i < 20; i++) stim_q.push_back(1'b1);
    req = 4'b0010;
    run_frame(1'b1, 0, 1'b0, 1'b0);
    chk("sat_count", 32'(last_count), 32'd15);

    // reset in the middle of a stream
    set_len(2, 10);
    req = 4'b0100;
    begin
      int waited;
      waited = 0;
      while (gnt == '0 && waited < 20) begin
        tick();
        waited++;
      end
    end
    chk("mid_grant", 32'(gnt), 32'b0100);
    req = '0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_bit = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    chk("mid_rst_gnt", 32'(gnt), 32'd0);
    chk("mid_rst_res_valid", 32'(res_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    m_ptr = 0;
    m_pat = '0;
    m_plen = 0;
    set_len(0, 4);
    set_len(3, 4);
    req = 4'b1001;
    run_frame(1'b1, 0, 1'b0, 1'b0);
    chk("post_rst_id", 32'(last_id), 32'd0);

    // randomized frames
    for (int it = 0; it < 40; it++) begin
      req = 4'($urandom_range(1, 15));
      for (int i = 0; i < NUM_REQ; i++) set_len(i, $urandom_range(0, 20));
      if ($urandom_range(0, 2) == 0) begin
        if ($urandom_range(0, 3) == 0) cfg_set(8'($urandom), $urandom_range(0, 15));
        else cfg_set(8'($urandom), $urandom_range(1, 4));
      end
      run_frame(1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b1);
    end
    req = '0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
